multicycle_ctrl: RTL

- Multicycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and writeback, and drives the immediate-extend select (ImmSrc), the ALU, and the mux and enable signals.
- Memory accesses go through the cache with a req/ready handshake, so misses stall the FSM.
- Supports lw, sw, R-type ALU, I-type ALU and beq. All other opcodes raise Illegal.

---
 rtl/riscv_ctrl_pkg.sv | 62 ++++++
 rtl/alu_decoder.sv | 31 +++
 rtl/multicycle_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multicycle controller: FSM states, opcodes
// and the select/ALU codes driven onto the datapath.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StBeq,
        StIllegal
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_DEC = 2'b10;

    // State following DECODE for a given opcode.
    function automatic state_e decode_next(input logic [6:0] op);
        case (op)
            OP_LW, OP_SW: return StMemAdr;
            OP_R:         return StExecR;
            OP_I:         return StExecI;
            OP_BEQ:       return StBeq;
            default:      return StIllegal;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's coarse ALUOp plus instruction fields to an ALUControl
// code. ALUOp 11 is unused and falls back to add.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_DEC: begin
                case (funct3)
                    // addi shares funct3 000; only R-type (op5=1) can subtract.
                    3'b000:  ALUControl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default:   ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback with a
// req/ready cache handshake and a retired-instruction counter.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             MemWE,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             Illegal,
    output logic [CNT_W-1:0] Retired
);

    state_e     state_q, state_d;
    logic       retire;
    logic [1:0] alu_op;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:    if (MemReady) state_d = StDecode;
            StDecode:   state_d = decode_next(op);
            StMemAdr:   state_d = (op == OP_SW) ? StMemWrite : StMemRead;
            StMemRead:  if (MemReady) state_d = StMemWb;
            StMemWrite: if (MemReady) state_d = StFetch;
            StExecR,
            StExecI:    state_d = StAluWb;
            StMemWb,
            StAluWb,
            StBeq,
            StIllegal:  state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    // ILLEGAL returns to FETCH without counting as a completed instruction.
    assign retire = (state_q == StMemWb) || (state_q == StAluWb) || (state_q == StBeq) ||
                    ((state_q == StMemWrite) && MemReady);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            Retired <= '0;
        end else begin
            state_q <= state_d;
            if (retire) Retired <= Retired + CNT_W'(1);
        end
    end

    always_comb begin
        MemReq    = 1'b0;
        MemWE     = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ResultSrc = RES_ALUOUT;
        ImmSrc    = IMM_I;
        Illegal   = 1'b0;
        alu_op    = ALUOP_ADD;
        unique case (state_q)
            StFetch: begin
                MemReq    = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            StDecode: begin
                // Branch target is computed early and parked in ALUOut.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
            end
            StMemAdr: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_SW) ? IMM_S : IMM_I;
            end
            StMemRead: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
            end
            StMemWb: begin
                ResultSrc = RES_RDATA;
                RegWrite  = 1'b1;
            end
            StMemWrite: begin
                MemReq = 1'b1;
                MemWE  = 1'b1;
                AdrSrc = 1'b1;
            end
            StExecR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                alu_op  = ALUOP_DEC;
            end
            StExecI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_I;
                alu_op  = ALUOP_DEC;
            end
            StAluWb: begin
                RegWrite = 1'b1;
            end
            StBeq: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                alu_op  = ALUOP_SUB;
                PCWrite = Zero;
            end
            StIllegal: begin
                Illegal = 1'b1;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .ALUOp      (alu_op),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .ALUControl (ALUControl)
    );

endmodule
